mem_arbiter: RTL and testbench

Shares the single multi-cycle unified main memory between the instruction-cache and data-cache miss handlers of the five-stage pipeline. It grants one requester at a time, sequences an 8-word block fill (pipelined address issue, in-order data return) or a single-word write-through store, and signals per-word validity and completion back to the owning cache. It sits between the two cache controllers and the memory model, below the IF and MEM stages.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/word_counter.sv | 32 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the I/D memory arbiter: state codes,
// default geometry and block-address arithmetic.
package mem_arbiter_pkg;

    localparam int WORDS_DEF   = 8;
    localparam int MEM_LAT_DEF = 4;
    localparam int CNT_W       = 3;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_FILL_I = 2'd1;
    localparam state_t S_FILL_D = 2'd2;
    localparam state_t S_WRITE  = 2'd3;

    // Byte-offset bits inside one block of WORDS_DEF 16-bit words.
    localparam logic [15:0] BLOCK_OFFS_MASK = 16'(2 * WORDS_DEF - 1);

    function automatic logic [15:0] block_base(input logic [15:0] addr,
                                               input logic [15:0] offs_mask);
        return addr & ~offs_mask;
    endfunction

endpackage

// File: rtl/word_counter.sv
// Small wrapping word counter with synchronous clear, increment enable and
// a terminal-count flag; used for both address issue and data receive.
module word_counter
    import mem_arbiter_pkg::*;
#(
    parameter int              WIDTH = CNT_W,
    parameter logic [WIDTH-1:0] LAST = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared main memory between I-cache and D-cache miss handlers:
// D-first fixed priority, 8-word pipelined block fills and single-word stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int WORDS   = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic        fill_valid,
    output logic [2:0]  fill_idx,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam logic [15:0]      OFFS_MASK = 16'(2 * WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS - 1);

    // The counters are 3 bits wide, so the geometry is fixed at 8 words.
    generate
        if (WORDS != 8 || MEM_LAT < 1) begin : g_param_check
            $error("mem_arbiter: WORDS must be 8 and MEM_LAT at least 1");
        end
    endgenerate

    state_t           state_reg, state_next;
    logic [15:0]      addr_reg;
    logic [15:0]      wdata_reg;
    logic             issue_done_reg;

    logic             in_fill;
    logic             in_write;
    logic             issuing;
    logic             last_word;
    logic [CNT_W-1:0] issue_cnt, recv_cnt;
    logic             issue_tc, recv_tc;
    logic [15:0]      base_addr;

    assign in_fill   = (state_reg == S_FILL_I) || (state_reg == S_FILL_D);
    assign in_write  = (state_reg == S_WRITE);
    assign issuing   = in_fill && !issue_done_reg;
    assign fill_valid = in_fill && mem_rvalid;
    assign last_word = fill_valid && recv_tc;
    assign base_addr = block_base(addr_reg, OFFS_MASK);

    word_counter #(.WIDTH(CNT_W), .LAST(LAST_IDX)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_fill),
        .inc   (issuing),
        .count (issue_cnt),
        .tc    (issue_tc)
    );

    word_counter #(.WIDTH(CNT_W), .LAST(LAST_IDX)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_fill),
        .inc   (fill_valid),
        .count (recv_cnt),
        .tc    (recv_tc)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (d_req) begin
                    state_next = d_we ? S_WRITE : S_FILL_D;
                end else if (i_req) begin
                    state_next = S_FILL_I;
                end
            end
            S_FILL_I, S_FILL_D: begin
                if (last_word) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            issue_done_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE) begin
                issue_done_reg <= 1'b0;
                if (d_req) begin
                    addr_reg  <= d_addr;
                    wdata_reg <= d_wdata;
                end else if (i_req) begin
                    addr_reg <= i_addr;
                end
            end else if (issuing && issue_tc) begin
                // Counter wraps to 0 here; this flag is what stops issue.
                issue_done_reg <= 1'b1;
            end
        end
    end

    assign i_grant   = (state_reg == S_FILL_I);
    assign d_grant   = (state_reg == S_FILL_D) || in_write;
    assign mem_en    = issuing || in_write;
    assign mem_wr    = in_write;
    assign mem_addr  = in_write ? addr_reg :
                       issuing  ? base_addr + 16'({issue_cnt, 1'b0}) : 16'h0000;
    assign mem_wdata = in_write ? wdata_reg : 16'h0000;
    assign fill_idx  = in_fill ? recv_cnt : '0;
    assign fill_data = fill_valid ? mem_rdata : 16'h0000;
    assign i_done    = last_word && (state_reg == S_FILL_I);
    assign d_done    = (last_word && (state_reg == S_FILL_D)) || in_write;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a behavioural memory
// and a cycle-table reference of fills and stores.
module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int WORDS   = 8;
    localparam int LAST_C  = MEM_LAT + WORDS - 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, d_grant, fill_valid, i_done, d_done;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model: fixed latency read pipe, writes on the clock edge.
    logic        pipe_clr;
    logic        spur;
    logic [15:0] seed;
    logic        pipe_v [MEM_LAT];
    logic [15:0] pipe_a [MEM_LAT];
    logic [15:0] mem_model [32768];
    logic [15:0] ref_wr [int];

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .i_grant    (i_grant),
        .d_grant    (d_grant),
        .fill_valid (fill_valid),
        .fill_idx   (fill_idx),
        .fill_data  (fill_data),
        .i_done     (i_done),
        .d_done     (d_done),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    function automatic logic [15:0] init_word(input int idx, input logic [15:0] s);
        return 16'(idx * 40503) ^ s;
    endfunction

    always @(posedge clk) begin
        if (pipe_clr) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= 16'h0000;
            end
            for (int i = 0; i < 32768; i++) mem_model[i] <= init_word(i, seed);
        end else begin
            pipe_v[0] <= mem_en & ~mem_wr;
            pipe_a[0] <= mem_addr;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            if (mem_en && mem_wr) mem_model[mem_addr[15:1]] <= mem_wdata;
        end
    end

    assign mem_rvalid = pipe_v[MEM_LAT-1] | spur;
    assign mem_rdata  = mem_model[pipe_a[MEM_LAT-1][15:1]];

    function automatic logic [15:0] ref_word(input int widx);
        if (ref_wr.exists(widx)) return ref_wr[widx];
        return init_word(widx, seed);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".i_grant"},    16'(i_grant),    16'h0);
        chk({tag, ".d_grant"},    16'(d_grant),    16'h0);
        chk({tag, ".mem_en"},     16'(mem_en),     16'h0);
        chk({tag, ".mem_wr"},     16'(mem_wr),     16'h0);
        chk({tag, ".mem_addr"},   mem_addr,        16'h0);
        chk({tag, ".mem_wdata"},  mem_wdata,       16'h0);
        chk({tag, ".fill_valid"}, 16'(fill_valid), 16'h0);
        chk({tag, ".fill_idx"},   16'(fill_idx),   16'h0);
        chk({tag, ".i_done"},     16'(i_done),     16'h0);
        chk({tag, ".d_done"},     16'(d_done),     16'h0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, ".i_grant"}, 16'(i_grant), 16'h0);
        chk({tag, ".d_grant"}, 16'(d_grant), 16'h0);
        chk({tag, ".mem_en"},  16'(mem_en),  16'h0);
        chk({tag, ".fill_valid"}, 16'(fill_valid), 16'h0);
        chk({tag, ".done"}, 16'({i_done, d_done}), 16'h0);
    endtask

    // Called at a negedge; the next rising edge is the grant edge E0.
    task automatic run_fill(input logic side_d, input logic [15:0] addr, input int drop_cyc);
        logic [15:0] base;
        logic        exp_en, exp_v, exp_done;
        base = addr & 16'hFFF0;
        if (side_d) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = addr; d_wdata = 16'($urandom);
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int c = 0; c <= LAST_C; c++) begin
            @(negedge clk);
            if (c == drop_cyc) i_req = 1'b0;
            exp_en   = (c < WORDS);
            exp_v    = (c >= MEM_LAT);
            exp_done = (c == LAST_C);
            chk("fill.i_grant", 16'(i_grant), 16'(!side_d));
            chk("fill.d_grant", 16'(d_grant), 16'(side_d));
            chk("fill.mem_en",  16'(mem_en),  16'(exp_en));
            chk("fill.mem_wr",  16'(mem_wr),  16'h0);
            chk("fill.mem_addr", mem_addr, exp_en ? base + 16'(2 * c) : 16'h0);
            chk("fill.fill_valid", 16'(fill_valid), 16'(exp_v));
            if (exp_v) begin
                chk("fill.fill_idx",  16'(fill_idx), 16'(c - MEM_LAT));
                chk("fill.fill_data", fill_data, ref_word(int'(base >> 1) + c - MEM_LAT));
            end
            chk("fill.i_done", 16'(i_done), 16'(exp_done && !side_d));
            chk("fill.d_done", 16'(d_done), 16'(exp_done && side_d));
        end
        if (side_d) d_req = 1'b0; else i_req = 1'b0;
        $display("fill side=%s addr=%h base=%h done", side_d ? "D" : "I", addr, base);
    endtask

    task automatic run_write(input logic [15:0] addr, input logic [15:0] data);
        d_req = 1'b1; d_we = 1'b1; d_addr = addr; d_wdata = data;
        @(negedge clk);
        chk("wr.d_grant",   16'(d_grant), 16'h1);
        chk("wr.i_grant",   16'(i_grant), 16'h0);
        chk("wr.mem_en",    16'(mem_en),  16'h1);
        chk("wr.mem_wr",    16'(mem_wr),  16'h1);
        chk("wr.mem_addr",  mem_addr,     addr);
        chk("wr.mem_wdata", mem_wdata,    data);
        chk("wr.d_done",    16'(d_done),  16'h1);
        chk("wr.i_done",    16'(i_done),  16'h0);
        chk("wr.fill_valid", 16'(fill_valid), 16'h0);
        ref_wr[int'(addr >> 1)] = data;
        d_req = 1'b0; d_we = 1'b0;
        $display("write addr=%h data=%h", addr, data);
    endtask

    initial begin
        rst_n = 1'b0; pipe_clr = 1'b1; spur = 1'b0; seed = 16'($urandom);
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1; pipe_clr = 1'b0;
        check_idle("post_reset");

        // Plain I fill, then a store, then a spurious return while idle.
        run_fill(1'b0, 16'h0136, 99);
        check_idle("after_ifill");
        run_write(16'h2002, 16'hBEEF);
        check_idle("after_write");
        spur = 1'b1;
        #1;
        chk("spur_idle.fill_valid", 16'(fill_valid), 16'h0);
        chk("spur_idle.fill_idx",   16'(fill_idx),   16'h0);
        run_write(16'h3ABC, 16'h1234);
        spur = 1'b0;
        check_idle("after_spur_write");

        // Simultaneous requests: D first, one idle cycle, then I.
        i_req = 1'b1; i_addr = 16'h0500;
        run_fill(1'b1, 16'h4000, 99);
        check_idle("between_d_i");
        run_fill(1'b0, 16'h0500, 99);
        check_idle("after_pair");

        // I request dropped mid-fill still completes.
        run_fill(1'b0, 16'h7F2A, 3);
        check_idle("after_drop");

        // Reset in the middle of a fill.
        i_req = 1'b1; i_addr = 16'h1110;
        repeat (6) @(negedge clk);
        rst_n = 1'b0; i_req = 1'b0;
        #1;
        chk_all_zero("midfill_reset");
        @(negedge clk);
        chk_all_zero("in_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) check_idle("late_returns");
        $display("reset mid-fill recovered");
        run_fill(1'b0, 16'h1110, 99);
        check_idle("after_restart");

        // Randomized transaction mix.
        for (int t = 0; t < 24; t++) begin
            int kind;
            logic [15:0] a;
            kind = int'($urandom_range(0, 2));
            a = 16'($urandom);
            if (kind == 2) run_write(a, 16'($urandom));
            else            run_fill(kind == 1, a, 99);
            check_idle("rand_idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
